// File: rtl/apb_bridge_pkg.sv
// Shared types and defaults for the APB4 multi-slave bridge.
`include "apb_defines.svh"
package apb_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_bridge_state_e;

  typedef struct packed {
    logic                         write;
    logic [`APB_ADDR_WIDTH-1:0]   addr;
    logic [`APB_DATA_WIDTH-1:0]   wdata;
    logic [`APB_DATA_WIDTH/8-1:0] strb;
    logic [`APB_PROT_WIDTH-1:0]   prot;
  } apb_bridge_req_t;

  localparam int unsigned DEFAULT_NUM_SLAVES  = 4;
  localparam int unsigned DEFAULT_REGION_BITS = 12;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational address decoder: picks the slave window and flags unmapped addresses.
`include "apb_defines.svh"
module apb_addr_decoder
  import apb_bridge_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = `APB_ADDR_WIDTH,
  parameter int unsigned NUM_SLAVES  = DEFAULT_NUM_SLAVES,
  parameter int unsigned REGION_BITS = DEFAULT_REGION_BITS,
  localparam int unsigned IDX_W      = idx_width(NUM_SLAVES)
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [IDX_W-1:0]      idx,
  output logic                  mapped
);

  logic unused_offset;

  assign idx    = addr[REGION_BITS +: IDX_W];
  assign mapped = (32'(idx) < NUM_SLAVES) && ((addr >> (REGION_BITS + IDX_W)) == '0);

  // The byte offset inside a window never affects the decode.
  assign unused_offset = ^addr[REGION_BITS-1:0];

endmodule

// File: rtl/apb_defines.svh
// Default APB bus widths shared by the bridge, its decoder and future interconnects.
`ifndef APB_DEFINES_SVH
`define APB_DEFINES_SVH
`define APB_ADDR_WIDTH 32
`define APB_DATA_WIDTH 32
`define APB_PROT_WIDTH 3
`endif

// File: rtl/apb_multi_slave_bridge.sv
// APB4 requester bridge: valid/ready request port to NUM_SLAVES APB slaves with timeout.
`include "apb_defines.svh"
module apb_multi_slave_bridge
  import apb_bridge_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = `APB_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = `APB_DATA_WIDTH,
  parameter int unsigned PROT_WIDTH     = `APB_PROT_WIDTH,
  parameter int unsigned NUM_SLAVES     = DEFAULT_NUM_SLAVES,
  parameter int unsigned REGION_BITS    = DEFAULT_REGION_BITS,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  localparam int unsigned STRB_WIDTH    = DATA_WIDTH / 8,
  localparam int unsigned IDX_W         = idx_width(NUM_SLAVES)
) (
  input  logic                             PCLK,
  input  logic                             PRESET,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_write,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic [DATA_WIDTH-1:0]            req_wdata,
  input  logic [STRB_WIDTH-1:0]            req_strb,
  input  logic [PROT_WIDTH-1:0]            req_prot,
  output logic                             rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_err,
  output logic [NUM_SLAVES-1:0]            PSEL,
  output logic                             PENABLE,
  output logic                             PWRITE,
  output logic [ADDR_WIDTH-1:0]            PADDR,
  output logic [DATA_WIDTH-1:0]            PWDATA,
  output logic [STRB_WIDTH-1:0]            PSTRB,
  output logic [PROT_WIDTH-1:0]            PPROT,
  input  logic [NUM_SLAVES-1:0]            PREADY,
  input  logic [NUM_SLAVES-1:0]            PSLVERR,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA
);

  localparam int unsigned     CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

  apb_bridge_state_e state, state_next;

  logic [IDX_W-1:0]      dec_idx;
  logic                  dec_mapped;
  logic [IDX_W-1:0]      idx_q;
  logic [CNT_W-1:0]      wait_cnt;
  logic                  accept;
  logic                  sel_ready;
  logic                  sel_err;
  logic [DATA_WIDTH-1:0] sel_rdata;
  logic                  timeout_hit;
  logic                  access_done;

  apb_addr_decoder #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .NUM_SLAVES  (NUM_SLAVES),
    .REGION_BITS (REGION_BITS)
  ) u_decoder (
    .addr   (req_addr),
    .idx    (dec_idx),
    .mapped (dec_mapped)
  );

  assign req_ready   = (state == IDLE) && !PRESET;
  assign accept      = req_valid && req_ready;
  assign sel_ready   = PREADY[idx_q];
  assign sel_err     = PSLVERR[idx_q];
  assign sel_rdata   = PRDATA[idx_q*DATA_WIDTH +: DATA_WIDTH];
  // Ready on the final counted cycle still wins because sel_ready is checked first.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == CNT_LAST);
  assign access_done = sel_ready || timeout_hit;

  always_ff @(posedge PCLK) begin
    if (PRESET) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = dec_mapped ? SETUP : RESP;
      SETUP:   state_next = ACCESS;
      ACCESS:  if (access_done) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      PSEL      <= '0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      PSTRB     <= '0;
      PPROT     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      idx_q     <= '0;
      wait_cnt  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            // Unmapped requests leave every bus output untouched.
            if (dec_mapped) begin
              idx_q  <= dec_idx;
              PSEL   <= NUM_SLAVES'(1) << dec_idx;
              PWRITE <= req_write;
              PADDR  <= req_addr;
              PWDATA <= req_write ? req_wdata : '0;
              PSTRB  <= req_write ? req_strb : '0;
              PPROT  <= req_prot;
            end else begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end
          end
        end
        SETUP: begin
          PENABLE  <= 1'b1;
          wait_cnt <= '0;
        end
        ACCESS: begin
          if (access_done) begin
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= sel_ready ? sel_err : 1'b1;
            rsp_rdata <= (sel_ready && !PWRITE) ? sel_rdata : '0;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_multi_slave_bridge.sv
// Scoreboard bench for apb_multi_slave_bridge with a behavioural four-slave APB model.
module tb_apb_multi_slave_bridge;
  import apb_bridge_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int PW = 3;
  localparam int NS = 4;
  localparam int RB = 12;
  localparam int TO = 16;

  logic           PCLK = 1'b0;
  logic           PRESET = 1'b1;
  logic           req_valid = 1'b0;
  logic           req_ready;
  logic           req_write = 1'b0;
  logic [AW-1:0]  req_addr = '0;
  logic [DW-1:0]  req_wdata = '0;
  logic [DW/8-1:0] req_strb = '0;
  logic [PW-1:0]  req_prot = '0;
  logic           rsp_valid;
  logic [DW-1:0]  rsp_rdata;
  logic           rsp_err;
  logic [NS-1:0]  PSEL;
  logic           PENABLE;
  logic           PWRITE;
  logic [AW-1:0]  PADDR;
  logic [DW-1:0]  PWDATA;
  logic [DW/8-1:0] PSTRB;
  logic [PW-1:0]  PPROT;
  logic [NS-1:0]  PREADY = '0;
  logic [NS-1:0]  PSLVERR = '0;
  logic [NS*DW-1:0] PRDATA = '0;

  apb_multi_slave_bridge #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .PROT_WIDTH     (PW),
    .NUM_SLAVES     (NS),
    .REGION_BITS    (RB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_strb  (req_strb),
    .req_prot  (req_prot),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PSTRB     (PSTRB),
    .PPROT     (PPROT),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR),
    .PRDATA    (PRDATA)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc_edge;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_bad = 0;
  int          edge_cnt = 0;
  int          acc_cnt = 0;
  int          psel_cnt = 0;
  int          slv_wait[NS];
  logic        slv_err[NS];
  logic [31:0] slv_data[NS];
  logic [NS-1:0] exp_psel = '0;
  logic [31:0] exp_paddr = '0;
  logic [31:0] exp_pwdata = '0;
  logic [7:0]  exp_pctl = '0;
  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h (edge %0d)", tag, got, exp, edge_cnt);
    end
  endtask

  always @(posedge PCLK) edge_cnt <= edge_cnt + 1;

  // Slave model: selected slave readies after slv_wait ACCESS cycles; idle slaves drive noise.
  always @(negedge PCLK) begin
    for (int i = 0; i < NS; i++) begin
      PRDATA[i*DW +: DW] = slv_data[i];
      if (PSEL[i] && PENABLE) begin
        PREADY[i]  = (acc_cnt >= slv_wait[i]);
        PSLVERR[i] = slv_err[i] && (acc_cnt >= slv_wait[i]);
      end else begin
        PREADY[i]  = 1'b1;
        PSLVERR[i] = 1'b1;
      end
    end
    if (PENABLE) acc_cnt = acc_cnt + 1;
    else         acc_cnt = 0;
  end

  always @(negedge PCLK) begin
    if (PRESET) begin
      psel_cnt   = 0;
      last_rdata = '0;
      last_err   = 1'b0;
    end else begin
      if (PSEL != '0) begin
        check_val("psel", PSEL, exp_psel);
        check_val("paddr", PADDR, exp_paddr);
        check_val("pctl", {PWRITE, PSTRB, PPROT}, exp_pctl);
        check_val("pwdata", PWDATA, exp_pwdata);
        check_val("penable", PENABLE, psel_cnt != 0);
        psel_cnt++;
      end
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          check_val("rsp_unexpected", rsp_valid, 0);
        end else begin
          mon_e = sb.pop_front();
          check_val("rsp_rdata", rsp_rdata, mon_e.rdata);
          check_val("rsp_err", rsp_err, mon_e.err);
          check_val("latency", edge_cnt - mon_e.acc_edge, mon_e.lat);
          check_val("psel_cycles", psel_cnt, mon_e.lat);
          last_rdata = mon_e.rdata;
          last_err   = mon_e.err;
        end
        psel_cnt = 0;
      end else begin
        check_val("rdata_hold", rsp_rdata, last_rdata);
        check_val("err_hold", rsp_err, last_err);
      end
    end
  end

  function automatic apb_bridge_req_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                                         input logic [3:0] s, input logic [2:0] p);
    apb_bridge_req_t r;
    r.write = w;
    r.addr  = a;
    r.wdata = d;
    r.strb  = s;
    r.prot  = p;
    return r;
  endfunction

  task automatic wait_ready();
    int guard = 0;
    @(negedge PCLK);
    while (!req_ready && guard < 200) begin
      @(negedge PCLK);
      guard++;
    end
  endtask

  task automatic drive(input apb_bridge_req_t r, input bit mapped);
    exp_psel   = mapped ? (NS'(1) << r.addr[RB +: 2]) : '0;
    exp_paddr  = r.addr;
    exp_pwdata = r.write ? r.wdata : '0;
    exp_pctl   = {r.write, (r.write ? r.strb : 4'h0), r.prot};
    req_write  = r.write;
    req_addr   = r.addr;
    req_wdata  = r.wdata;
    req_strb   = r.strb;
    req_prot   = r.prot;
    req_valid  = 1'b1;
  endtask

  // lat: edges from accept to the edge that raises rsp_valid, minus one (0 = unmapped).
  task automatic issue(input apb_bridge_req_t r, input int lat, input logic [31:0] erd, input logic eerr);
    exp_t e;
    wait_ready();
    if (!req_ready) begin
      check_val("req_ready_wait", req_ready, 1);
      return;
    end
    drive(r, lat != 0);
    e.rdata    = erd;
    e.err      = eerr;
    e.lat      = lat;
    e.acc_edge = edge_cnt + 1;
    sb.push_back(e);
    @(posedge PCLK);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      @(negedge PCLK);
      guard++;
    end
    if (sb.size() != 0) check_val("drain", sb.size(), 0);
    @(negedge PCLK);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_ctl"}, {PSEL, PENABLE, PWRITE, PSTRB, PPROT}, 0);
    check_val({tag, "_paddr"}, PADDR, 0);
    check_val({tag, "_pwdata"}, PWDATA, 0);
    check_val({tag, "_rsp"}, {rsp_valid, rsp_err}, 0);
    check_val({tag, "_rdata"}, rsp_rdata, 0);
    check_val({tag, "_ready"}, req_ready, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    slv_wait = '{0, 0, 0, 2};
    slv_err  = '{1'b0, 1'b0, 1'b0, 1'b0};
    slv_data = '{32'hA0A0_0000, 32'hB1B1_1111, 32'hC2C2_2222, 32'h1234_5678};

    PRESET = 1'b1;
    repeat (3) @(negedge PCLK);
    check_reset_outputs("reset");
    PRESET = 1'b0;
    #1 check_val("ready_after_reset", req_ready, 1);

    issue(mk(1'b1, 32'h0000_1010, 32'hDEAD_BEEF, 4'hF, 3'b000), 2, 32'h0, 1'b0);
    issue(mk(1'b0, 32'h0000_3004, 32'h5555_5555, 4'hF, 3'b010), 4, 32'h1234_5678, 1'b0);
    issue(mk(1'b0, 32'h0000_4000, 32'h0, 4'h0, 3'b000), 0, 32'h0, 1'b1);
    issue(mk(1'b1, 32'h8000_0000, 32'h1111_2222, 4'h3, 3'b001), 0, 32'h0, 1'b1);
    issue(mk(1'b0, 32'h0000_2FFC, 32'h0, 4'h0, 3'b111), 2, 32'hC2C2_2222, 1'b0);
    issue(mk(1'b1, 32'h0000_1000, 32'h0BAD_F00D, 4'h5, 3'b100), 2, 32'h0, 1'b0);
    issue(mk(1'b0, 32'h0000_0004, 32'h0, 4'h0, 3'b000), 2, 32'hA0A0_0000, 1'b0);
    wait_idle();

    slv_wait[2] = 255;
    issue(mk(1'b0, 32'h0000_2008, 32'h0, 4'h0, 3'b000), 17, 32'h0, 1'b1);
    wait_idle();
    slv_wait[2] = 16;
    issue(mk(1'b0, 32'h0000_2008, 32'h0, 4'h0, 3'b000), 17, 32'h0, 1'b1);
    wait_idle();
    slv_wait[2] = 15;
    issue(mk(1'b0, 32'h0000_2008, 32'h0, 4'h0, 3'b000), 17, 32'hC2C2_2222, 1'b0);
    wait_idle();

    slv_wait[2] = 0;
    slv_err[0]  = 1'b1;
    issue(mk(1'b1, 32'h0000_0FFC, 32'h7777_8888, 4'hC, 3'b000), 2, 32'h0, 1'b1);
    issue(mk(1'b0, 32'h0000_0000, 32'h0, 4'h0, 3'b000), 2, 32'hA0A0_0000, 1'b1);
    wait_idle();

    slv_err[0]  = 1'b0;
    slv_wait[0] = 5;
    wait_ready();
    drive(mk(1'b0, 32'h0000_0100, 32'h0, 4'h0, 3'b000), 1'b1);
    @(posedge PCLK);
    #1 req_valid = 1'b0;
    for (int i = 0; i < 10 && !PENABLE; i++) @(negedge PCLK);
    check_val("reach_access", PENABLE, 1);
    PRESET = 1'b1;
    @(negedge PCLK);
    check_reset_outputs("midreset");
    @(negedge PCLK);
    PRESET = 1'b0;
    #1 check_val("ready_after_midreset", req_ready, 1);
    repeat (10) @(negedge PCLK);

    slv_wait[0] = 0;
    issue(mk(1'b0, 32'h0000_0008, 32'h0, 4'h0, 3'b000), 2, 32'hA0A0_0000, 1'b0);
    wait_idle();
    check_val("drain_final", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/apb_multi_slave_bridge.md
# apb_multi_slave_bridge

Parametrised APB4 requester bridge that turns a simple valid/ready request port into APB4 transfers to `NUM_SLAVES` slaves. It decodes the address to a per-slave `PSEL`, muxes `PREADY`/`PRDATA`/`PSLVERR` back, and terminates hung transfers with a timeout. Unmapped accesses complete with an error and never touch the bus. It is the next-generation replacement for the single-master/single-slave wrapper and sits between the RAM test harness or CPU-side logic and multiple APB peripherals.

## Interface
- `ADDR_WIDTH`, default `` `APB_ADDR_WIDTH ``: address width.
- `DATA_WIDTH`, default `` `APB_DATA_WIDTH ``: data width; `STRB_WIDTH = DATA_WIDTH/8`.
- `PROT_WIDTH`, default `` `APB_PROT_WIDTH ``: PPROT width.
- `NUM_SLAVES`, default 4: number of slaves, range 1–16; `IDX_W = max(1, $clog2(NUM_SLAVES))`.
- `REGION_BITS`, default 12: each slave owns a `2**REGION_BITS`-byte window.
- `TIMEOUT_CYCLES`, default 16: maximum ACCESS cycles before a forced error; 0 disables the timeout.
- Ports:
  - `PCLK` in 1: clock; all logic is rising-edge.
  - `PRESET` in 1: synchronous, active-high reset.
  - `req_valid` in 1: request present.
  - `req_ready` out 1: bridge can accept a request.
  - `req_write` in 1: 1 = write, 0 = read.
  - `req_addr` in `ADDR_WIDTH`: byte address.
  - `req_wdata` in `DATA_WIDTH`: write data.
  - `req_strb` in `STRB_WIDTH`: write byte strobes.
  - `req_prot` in `PROT_WIDTH`: protection attributes.
  - `rsp_valid` out 1: one-cycle completion pulse.
  - `rsp_rdata` out `DATA_WIDTH`: read data.
  - `rsp_err` out 1: slave error, timeout or unmapped address.
  - `PSEL` out `NUM_SLAVES`: one-hot slave select.
  - `PENABLE`, `PWRITE` out 1: APB4 control.
  - `PADDR` out `ADDR_WIDTH`; `PWDATA` out `DATA_WIDTH`; `PSTRB` out `STRB_WIDTH`; `PPROT` out `PROT_WIDTH`.
  - `PREADY` in `NUM_SLAVES`: per-slave ready.
  - `PSLVERR` in `NUM_SLAVES`: per-slave error.
  - `PRDATA` in `NUM_SLAVES*DATA_WIDTH`: slave `i` drives bits `[i*DATA_WIDTH +: DATA_WIDTH]`.

## Operation
- States:
  - IDLE: `req_ready`=1.
  - SETUP
  - ACCESS
  - RESP
- Accept: `req_valid & req_ready` in IDLE latches addr, wdata, strb, prot, write and the decoded index.
- Decode:
  - `idx = req_addr[REGION_BITS +: IDX_W]`.
  - The access is mapped iff `idx < NUM_SLAVES` and all of `req_addr[ADDR_WIDTH-1 : REGION_BITS+IDX_W]` are 0.
- Mapped accesses: IDLE → SETUP → ACCESS.
- Unmapped accesses: IDLE → RESP with `rsp_err`=1 and `rsp_rdata`=0. No PSEL is asserted.
- SETUP:
  - `PSEL[idx]`=1, `PENABLE`=0.
  - PADDR, PWRITE, PWDATA, PSTRB and PPROT are driven from the latched request.
  - PADDR is the full `req_addr`; it is not rebased.
- ACCESS:
  - `PENABLE`=1; all APB outputs are held stable.
  - Completion: when `PREADY[idx]`=1, capture `PRDATA[idx]` (reads only; writes leave `rsp_rdata`=0) and `rsp_err=PSLVERR[idx]`, then go to RESP.
  - Timeout: count ACCESS cycles with PREADY low. When the count reaches `TIMEOUT_CYCLES` without ready, go to RESP with `rsp_err`=1 and `rsp_rdata`=0.
  - PREADY arriving on the same cycle as the timeout count is reached wins: the transfer completes normally.
- RESP: `rsp_valid`=1 for exactly one cycle, PSEL/PENABLE=0, then IDLE.
- Reads drive `PSTRB`=0 (APB4 rule). PWDATA is don't-care on reads; drive 0.
- PREADY/PSLVERR/PRDATA of unselected slaves are ignored.
- `rsp_rdata`/`rsp_err` hold their values until the next RESP.

## Timing
- Reset values: `req_ready`=0 during reset and 1 in the first cycle after PRESET deasserts. All of `PSEL`, `PENABLE`, `PWRITE`, `PADDR`, `PWDATA`, `PSTRB`, `PPROT`, `rsp_valid`, `rsp_rdata` and `rsp_err` are 0.
- Reset mid-transfer: at the first PCLK edge with PRESET high, all outputs take their reset values and the in-flight request is dropped with no response.
- Latency, mapped with zero wait states: accept at edge N; SETUP in cycle N+1; ACCESS in cycle N+2 (PREADY sampled); `rsp_valid` in cycle N+3.
- Each wait state adds one cycle.
- Unmapped: `rsp_valid` in cycle N+1.
- Timeout: `rsp_valid` in cycle N+2+`TIMEOUT_CYCLES`.
- Back-to-back throughput is one zero-wait transfer per 4 cycles. `req_ready` is low in SETUP, ACCESS and RESP.
- All outputs are registered except `req_ready`, which is decoded from the state register.

## Structure
- Shared package `apb_bridge_pkg`:
  - `apb_bridge_state_e` (IDLE, SETUP, ACCESS, RESP).
  - Packed struct `apb_bridge_req_t` (write, addr, wdata, strb, prot).
  - Localparams for the default `NUM_SLAVES` and `REGION_BITS`.
- Width macros come from `apb_defines.svh`.
- Sub-module `apb_addr_decoder`: combinational; takes addr and outputs `idx` and `mapped`. It is reused by future interconnects.

## Test plan
- `NUM_SLAVES`=4, `REGION_BITS`=12, `TIMEOUT_CYCLES`=16 for all cases.
- Write 0xDEADBEEF, strb 0xF, to 0x00001010; slave 1 has PREADY=1 → `PSEL`=4'b0010 for 2 cycles, PADDR=0x00001010, `rsp_valid` at N+3 with `rsp_err`=0.
- Read 0x00003004; slave 3 returns 0x12345678 after 2 wait states → PSTRB=0, `rsp_rdata`=0x12345678, `rsp_valid` at N+5.
- Read 0x00004000 (unmapped) → no PSEL, `rsp_valid` at N+1, `rsp_err`=1, `rsp_rdata`=0.
- Slave 2 holds PREADY=0 → PSEL drops after 16 ACCESS cycles, `rsp_valid` at N+18 with `rsp_err`=1. A second run with PREADY rising on ACCESS cycle 16 completes normally with `rsp_err`=0.
- Slave 0 returns PSLVERR=1 on a write → `rsp_err`=1. Then assert PRESET during ACCESS of the next read → all outputs 0 next edge and no `rsp_valid`.
